// File: rtl/result_select_unit_if.sv
// Handshake and data bundle between the EX-stage operand sources, the result
// selector and writeback. The master side feeds ops in; the slave side is the selector.
interface result_select_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       funct;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] shift_out;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid,
        output funct,
        output alu_out,
        output shift_out,
        output src_a,
        output src_b,
        input  in_ready,
        input  data_out,
        input  out_valid,
        input  illegal,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  funct,
        input  alu_out,
        input  shift_out,
        input  src_a,
        input  src_b,
        output in_ready,
        output data_out,
        output out_valid,
        output illegal,
        output busy
    );
endinterface

// File: rtl/result_select_unit.sv
// EX-stage result selector: picks ALU/shifter results by funct, runs MULTU as a
// WIDTH-step shift-add into HI/LO, and serves MFHI/MFLO with a registered valid pulse.
module result_select_unit #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    result_select_unit_if.slave  bus
);

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        MULT
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 illegal_q, illegal_d;
    logic                 busy_q, busy_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    logic                 accept;
    logic [2*WIDTH-1:0]   step_sum;

    assign accept   = bus.in_valid && (state_q == IDLE);

    // Multiplicand is pre-shifted and the multiplier consumed LSB-first, so each
    // step only ever looks at mplier_q[0] and adds mcand_q unshifted.
    assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        data_d      = data_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.funct)
                        F_AND, F_OR, F_ADD, F_SUB, F_SLT: begin
                            data_d      = bus.alu_out;
                            out_valid_d = 1'b1;
                        end
                        F_SLL: begin
                            data_d      = bus.shift_out;
                            out_valid_d = 1'b1;
                        end
                        F_MFHI: begin
                            data_d      = hi_q;
                            out_valid_d = 1'b1;
                        end
                        F_MFLO: begin
                            data_d      = lo_q;
                            out_valid_d = 1'b1;
                        end
                        F_MULTU: begin
                            mcand_d  = {{WIDTH{1'b0}}, bus.src_a};
                            mplier_d = bus.src_b;
                            acc_d    = '0;
                            cnt_d    = '0;
                            busy_d   = 1'b1;
                            state_d  = MULT;
                        end
                        default: begin
                            data_d      = '0;
                            out_valid_d = 1'b1;
                            illegal_d   = 1'b1;
                        end
                    endcase
                end
            end

            MULT: begin
                acc_d    = step_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    hi_d        = step_sum[2*WIDTH-1:WIDTH];
                    lo_d        = step_sum[WIDTH-1:0];
                    data_d      = step_sum[WIDTH-1:0];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.data_out  = data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.illegal   = illegal_q;
    assign bus.busy      = busy_q;

endmodule
